boot_loader: RTL and testbench

UART program loader that sits directly upstream of the MIPS processor and its program memory. At power-up it holds the processor in reset and receives a length-prefixed program image over a serial line. It writes each assembled 32-bit word into program memory, then releases the processor to execute from address 0. Once a load completes or fails, it stays in that state until the next `reset`.

---
 rtl/boot_loader.sv | 216 +++++++++++++++++++++
 tb/tb_boot_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// UART program loader: receives a length-prefixed little-endian word image,
// writes it into program memory and holds the CPU in reset until it is complete.
module boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEMORY_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_i,
  output logic        prog_we_o,
  output logic [31:0] prog_addr_o,
  output logic [31:0] prog_data_o,
  output logic        cpu_reset_o,
  output logic        load_done_o,
  output logic        load_error_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR} ld_state_t;

  // Handshake: byte_valid is a single-cycle pulse with the received byte on
  // shift_q; there is no back-pressure, the loader must consume it that cycle.

  logic            rx_meta_q, rx_sync_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, frame_err;

  ld_state_t       ld_state_q, ld_state_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     len_in;
  logic [16:0]     word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     word_q, word_d;
  logic            prog_we_q, prog_we_d;
  logic [31:0]     prog_addr_q, prog_addr_d;
  logic [31:0]     prog_data_q, prog_data_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            load_done_q, load_done_d;
  logic            load_error_q, load_error_d;

  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign len_in = {shift_q, len_q[7:0]};

  always_comb begin
    ld_state_d   = ld_state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    case (ld_state_q)
      L_LEN0: begin
        if (frame_err) begin
          ld_state_d   = L_ERR;
          load_error_d = 1'b1;
        end else if (byte_valid) begin
          len_d[7:0] = shift_q;
          ld_state_d = L_LEN1;
        end
      end
      L_LEN1: begin
        if (frame_err) begin
          ld_state_d   = L_ERR;
          load_error_d = 1'b1;
        end else if (byte_valid) begin
          len_d = len_in;
          if (len_in == 16'd0) begin
            // Empty image: release straight away.
            ld_state_d  = L_DONE;
            cpu_reset_d = 1'b0;
            load_done_d = 1'b1;
          end else if ({16'd0, len_in} > 32'(MEMORY_DEPTH)) begin
            ld_state_d   = L_ERR;
            load_error_d = 1'b1;
          end else begin
            ld_state_d = L_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
      end
      L_DATA: begin
        if (frame_err) begin
          ld_state_d   = L_ERR;
          load_error_d = 1'b1;
        end else if (byte_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            prog_we_d   = 1'b1;
            prog_addr_d = {13'd0, word_idx_q, 2'b00};
            prog_data_d = {shift_q, word_q[23:0]};
            word_idx_d  = word_idx_q + 17'd1;
            // Release follows one cycle after this write via L_DONE.
            if (word_idx_q + 17'd1 == {1'b0, len_q}) ld_state_d = L_DONE;
          end
        end
      end
      L_DONE: begin
        cpu_reset_d = 1'b0;
        load_done_d = 1'b1;
      end
      L_ERR: begin
        cpu_reset_d  = 1'b1;
        load_error_d = 1'b1;
      end
      default: ld_state_d = L_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ld_state_q   <= L_LEN0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ld_state_q   <= ld_state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      prog_we_q    <= prog_we_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign prog_we_o    = prog_we_q;
  assign prog_addr_o  = prog_addr_q;
  assign prog_data_o  = prog_data_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign load_done_o  = load_done_q;
  assign load_error_o = load_error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: serial frames in, expected memory writes
// queued in a scoreboard and checked by an independent monitor.
module tb_boot_loader;
  localparam int CPB   = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_i = 1'b1;
  logic        prog_we_o;
  logic [31:0] prog_addr_o;
  logic [31:0] prog_data_o;
  logic        cpu_reset_o;
  logic        load_done_o;
  logic        load_error_o;

  boot_loader #(.CLKS_PER_BIT(CPB), .MEMORY_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i),
    .prog_we_o(prog_we_o), .prog_addr_o(prog_addr_o), .prog_data_o(prog_data_o),
    .cpu_reset_o(cpu_reset_o), .load_done_o(load_done_o), .load_error_o(load_error_o)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_rise_cyc = -1;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the queue.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    cyc++;
    if (load_done_o === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = load_done_o;
    if (prog_we_o === 1'b1) begin
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 prog_addr_o, prog_data_o);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {prog_addr_o, prog_data_o}, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic check_status(input string name, input logic cr, input logic dn, input logic er);
    check({name, "_cpu_reset"}, {63'd0, cpu_reset_o}, {63'd0, cr});
    check({name, "_load_done"}, {63'd0, load_done_o}, {63'd0, dn});
    check({name, "_load_error"}, {63'd0, load_error_o}, {63'd0, er});
  endtask

  initial begin
    // Reset with the line idle.
    reset = 1'b1;
    rx_i  = 1'b1;
    tick(100);
    check("rst_we", {63'd0, prog_we_o}, 64'd0);
    check("rst_addr", {32'd0, prog_addr_o}, 64'd0);
    check("rst_data", {32'd0, prog_data_o}, 64'd0);
    check_status("rst", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    tick(20);
    check_status("idle", 1'b1, 1'b0, 1'b0);

    // Two-word image.
    exp_q.push_back({32'h0000_0000, 32'h2008_0013});
    exp_q.push_back({32'h0000_0004, 32'hFFFF_FFFF});
    done_rise_cyc = -1;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h08); send_byte(8'h20);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    tick(10);
    check("two_word_drained", 64'(exp_q.size()), 64'd0);
    check_status("two_word", 1'b0, 1'b1, 1'b0);
    check("two_word_release_lag", 64'(done_rise_cyc - last_we_cyc), 64'd1);

    // Empty image, then trailing bytes must be ignored.
    do_reset(5);
    check_status("mid_reset", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00); send_byte(8'h00);
    tick(10);
    check_status("empty", 1'b0, 1'b1, 1'b0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h08); send_byte(8'h20);
    tick(10);
    check_status("empty_extra", 1'b0, 1'b1, 1'b0);

    // Oversize word count (257).
    do_reset(5);
    send_byte(8'h01); send_byte(8'h01);
    tick(10);
    check_status("oversize", 1'b1, 1'b0, 1'b1);

    // Framing error on the second byte.
    do_reset(5);
    send_byte(8'h01); send_byte(8'h00, 1'b0);
    tick(10);
    check_status("framing", 1'b1, 1'b0, 1'b1);

    // Reset after three bytes of word 0, false start, then a clean 1-word load.
    do_reset(5);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check_status("abandon", 1'b1, 1'b0, 1'b0);
    rx_i = 1'b0;
    tick(1);
    rx_i = 1'b1;
    tick(20);
    check_status("glitch", 1'b1, 1'b0, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'hDDCC_BBAA});
    done_rise_cyc = -1;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    tick(10);
    check("one_word_drained", 64'(exp_q.size()), 64'd0);
    check_status("one_word", 1'b0, 1'b1, 1'b0);
    check("one_word_release_lag", 64'(done_rise_cyc - last_we_cyc), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
